// File: rtl/rew_pkg.sv
// rtl/rew_pkg.sv - shared phase codes, issuer state encoding and helpers for the REW chunk issuer
// Purpose: phase-code constants {RO, Writeback}, the invalid-code flag bit,
//          the issuer FSM state type and a small max helper for sizing counters.
package rew_pkg;

    localparam logic [1:0] RW_R = 2'b00;
    localparam logic [1:0] RW_W = 2'b01;
    localparam logic [1:0] RO_R = 2'b10;
    localparam logic [1:0] RO_W = 2'b11;

    // Bit 2 of a 3-bit phase register marks "no valid phase".
    localparam int         PHASE_INVALID_BIT = 2;
    localparam logic [2:0] PHASE_NONE        = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rew_chunk_issuer_updown_ctr.sv
// rtl/rew_chunk_issuer_updown_ctr.sv - saturating up/down counter for outstanding reads
// Ports: Clock, Reset (sync, active-low), Clear (sync clear), Inc, Dec,
//        Count, Full (Count == Max), Empty (Count == 0).
module updown_ctr #(
    parameter int Width = 3,
    parameter int Max   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Inc,
    input  logic             Dec,
    output logic [Width-1:0] Count,
    output logic             Full,
    output logic             Empty
);

    assign Full  = (Count == Width'(Max));
    assign Empty = (Count == '0);

    // Simultaneous Inc and Dec cancel out.
    always_ff @(posedge Clock) begin
        if (!Reset || Clear) begin
            Count <= '0;
        end else if (Inc && !Dec && !Full) begin
            Count <= Count + 1'b1;
        end else if (Dec && !Inc && !Empty) begin
            Count <= Count - 1'b1;
        end
    end

endmodule

// File: rtl/rew_chunk_issuer.sv
// rtl/rew_chunk_issuer.sv - issues DRAM chunk commands per REW phase and pulses chunk transfers
// Ports: Clock, Reset (sync, active-low); phase flags RWAccess/ROAccess/Read/Writeback;
//        PathAddress (base, sampled on phase entry); DRAM command channel
//        (DRAMCommandValid/Ready/Command/Address); DRAMReadDataValid (read return);
//        per-phase Transfer pulses, PhaseDone pulse, sticky Error.
module rew_chunk_issuer
    import rew_pkg::*;
#(
    parameter int RW_R_Chunk     = 4,
    parameter int RW_W_Chunk     = 4,
    parameter int RO_R_Chunk     = 2,
    parameter int RO_W_Chunk     = 0,
    parameter int AddrWidth      = 32,
    parameter int ChunkShift     = 6,
    parameter int MaxOutstanding = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 RWAccess,
    input  logic                 ROAccess,
    input  logic                 Read,
    input  logic                 Writeback,
    input  logic [AddrWidth-1:0] PathAddress,
    output logic                 DRAMCommandValid,
    input  logic                 DRAMCommandReady,
    output logic                 DRAMCommand,
    output logic [AddrWidth-1:0] DRAMCommandAddress,
    input  logic                 DRAMReadDataValid,
    output logic                 RW_R_Transfer,
    output logic                 RW_W_Transfer,
    output logic                 RO_R_Transfer,
    output logic                 RO_W_Transfer,
    output logic                 PhaseDone,
    output logic                 Error
);

    localparam int MaxChunk = max_of4(RW_R_Chunk, RW_W_Chunk, RO_R_Chunk, RO_W_Chunk);
    localparam int IdxW     = $clog2(MaxChunk) + 1;
    localparam int OutW     = $clog2(MaxOutstanding) + 1;
    localparam logic [AddrWidth-1:0] Stride = AddrWidth'(1) << ChunkShift;

    state_t          state;
    logic [2:0]      phase_q;   // {invalid, RO, Writeback}, registered every cycle
    logic [2:0]      lat_q;     // code of the phase being worked on
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] n_q;
    logic [IdxW-1:0] n_sel;
    logic [OutW-1:0] out_cnt;
    logic [OutW-1:0] out_next;
    logic            out_full;
    logic            out_empty;

    logic flags_ok, entry, abort, is_read, accept, rd_acc, wr_acc;
    logic ret_ok, ret_bad, can_issue, idx_last;

    assign flags_ok  = (RWAccess ^ ROAccess) & (Read ^ Writeback);
    assign entry     = !phase_q[PHASE_INVALID_BIT] && (phase_q != lat_q);
    assign abort     = entry && (state == ISSUE || state == DRAIN);
    assign is_read   = !lat_q[0];
    assign accept    = DRAMCommandValid && DRAMCommandReady;
    assign rd_acc    = accept && !DRAMCommand;
    assign wr_acc    = accept && DRAMCommand;
    assign ret_ok    = DRAMReadDataValid && !out_empty;
    assign ret_bad   = DRAMReadDataValid && out_empty;
    assign out_next  = out_cnt + OutW'(rd_acc) - OutW'(ret_ok);
    assign can_issue = !is_read || (out_next < OutW'(MaxOutstanding));
    assign idx_last  = ((idx_q + 1'b1) == n_q);

    always_comb begin
        n_sel = '0;
        case (phase_q[1:0])
            RW_R:    n_sel = IdxW'(RW_R_Chunk);
            RW_W:    n_sel = IdxW'(RW_W_Chunk);
            RO_R:    n_sel = IdxW'(RO_R_Chunk);
            default: n_sel = IdxW'(RO_W_Chunk);
        endcase
    end

    updown_ctr #(.Width(OutW), .Max(MaxOutstanding)) u_outstanding (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (abort),
        .Inc   (rd_acc),
        .Dec   (ret_ok),
        .Count (out_cnt),
        .Full  (out_full),
        .Empty (out_empty)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state              <= IDLE;
            phase_q            <= PHASE_NONE;
            lat_q              <= PHASE_NONE;
            idx_q              <= '0;
            n_q                <= '0;
            DRAMCommandValid   <= 1'b0;
            DRAMCommand        <= 1'b0;
            DRAMCommandAddress <= '0;
            RW_R_Transfer      <= 1'b0;
            RW_W_Transfer      <= 1'b0;
            RO_R_Transfer      <= 1'b0;
            RO_W_Transfer      <= 1'b0;
            PhaseDone          <= 1'b0;
            Error              <= 1'b0;
        end else begin
            phase_q   <= {!flags_ok, ROAccess, Writeback};
            PhaseDone <= 1'b0;

            // Transfers belong to the phase that issued the chunk, so use the code before any relatch.
            RW_R_Transfer <= ret_ok && !lat_q[1];
            RO_R_Transfer <= ret_ok &&  lat_q[1];
            RW_W_Transfer <= wr_acc && !lat_q[1];
            RO_W_Transfer <= wr_acc &&  lat_q[1];

            if (ret_bad || abort) begin
                Error <= 1'b1;
            end

            if (entry) begin
                // A new phase always restarts from chunk 0; from ISSUE/DRAIN this is an abort.
                lat_q              <= phase_q;
                n_q                <= n_sel;
                idx_q              <= '0;
                DRAMCommandAddress <= PathAddress;
                DRAMCommand        <= phase_q[0];
                if (n_sel == '0) begin
                    state            <= DONE;
                    DRAMCommandValid <= 1'b0;
                    PhaseDone        <= 1'b1;
                end else begin
                    state            <= ISSUE;
                    DRAMCommandValid <= 1'b1;
                end
            end else begin
                case (state)
                    ISSUE: begin
                        if (accept) begin
                            idx_q              <= idx_q + 1'b1;
                            DRAMCommandAddress <= DRAMCommandAddress + Stride;
                            if (idx_last) begin
                                // Writes also pass through DRAIN (empty) so PhaseDone trails the last Transfer.
                                DRAMCommandValid <= 1'b0;
                                state            <= DRAIN;
                            end else begin
                                DRAMCommandValid <= can_issue;
                            end
                        end else if (!DRAMCommandValid) begin
                            // Stalled on outstanding limit; a return frees a slot for the next cycle.
                            DRAMCommandValid <= !is_read || !out_full || ret_ok;
                        end
                    end
                    DRAIN: begin
                        if (out_empty) begin
                            state     <= DONE;
                            PhaseDone <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rew_chunk_issuer.sv
// tb/tb_rew_chunk_issuer.sv - directed self-checking bench for rew_chunk_issuer
module tb_rew_chunk_issuer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        RWAccess = 1'b0, ROAccess = 1'b0, Read = 1'b0, Writeback = 1'b0;
    logic [31:0] PathAddress = 32'h0;
    logic        DRAMCommandReady = 1'b0;
    logic        DRAMReadDataValid = 1'b0;

    logic        v0, c0, rwr0, rww0, ror0, row0, pd0, er0;
    logic [31:0] a0;
    logic        v1, c1, rwr1, rww1, ror1, row1, pd1, er1;
    logic [31:0] a1;

    always #5 Clock = ~Clock;

    rew_chunk_issuer dut0 (
        .Clock(Clock), .Reset(Reset),
        .RWAccess(RWAccess), .ROAccess(ROAccess), .Read(Read), .Writeback(Writeback),
        .PathAddress(PathAddress),
        .DRAMCommandValid(v0), .DRAMCommandReady(DRAMCommandReady),
        .DRAMCommand(c0), .DRAMCommandAddress(a0),
        .DRAMReadDataValid(DRAMReadDataValid),
        .RW_R_Transfer(rwr0), .RW_W_Transfer(rww0), .RO_R_Transfer(ror0), .RO_W_Transfer(row0),
        .PhaseDone(pd0), .Error(er0)
    );

    rew_chunk_issuer #(.MaxOutstanding(1)) dut1 (
        .Clock(Clock), .Reset(Reset),
        .RWAccess(RWAccess), .ROAccess(ROAccess), .Read(Read), .Writeback(Writeback),
        .PathAddress(PathAddress),
        .DRAMCommandValid(v1), .DRAMCommandReady(DRAMCommandReady),
        .DRAMCommand(c1), .DRAMCommandAddress(a1),
        .DRAMReadDataValid(DRAMReadDataValid),
        .RW_R_Transfer(rwr1), .RW_W_Transfer(rww1), .RO_R_Transfer(ror1), .RO_W_Transfer(row1),
        .PhaseDone(pd1), .Error(er1)
    );

    // Observed DUT selected by dsel; o_xf is indexed by phase code.
    int          dsel = 0;
    logic        o_valid, o_cmd, o_done, o_err;
    logic [31:0] o_addr;
    logic [3:0]  o_xf;

    always_comb begin
        if (dsel == 1) begin
            o_valid = v1; o_cmd = c1; o_addr = a1; o_done = pd1; o_err = er1;
            o_xf    = {row1, ror1, rww1, rwr1};
        end else begin
            o_valid = v0; o_cmd = c0; o_addr = a0; o_done = pd0; o_err = er0;
            o_xf    = {row0, ror0, rww0, rwr0};
        end
    end

    typedef struct {
        logic [1:0]  code;
        logic [31:0] base;
        int          ready_mode;   // 0: always ready, 1: ready on odd cycles
        int          exp_n;
    } vec_t;

    vec_t        vecs[4];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] addr_log[16];
    int          acc_cyc[16];
    int          xf_cnt[4];
    int          n_cmd, done_cnt, done_cyc, last_xf_cyc, unstable, first_valid, cyc;
    int          ret_q[$];
    logic        prev_stall, prev_cmd;
    logic [31:0] prev_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_flags(input logic [1:0] code);
        RWAccess  = !code[1];
        ROAccess  =  code[1];
        Read      = !code[0];
        Writeback =  code[0];
    endtask

    task automatic clear_flags();
        RWAccess = 0; ROAccess = 0; Read = 0; Writeback = 0;
    endtask

    task automatic do_reset();
        Reset = 0;
        clear_flags();
        DRAMCommandReady  = 0;
        DRAMReadDataValid = 0;
        tick();
        tick();
        Reset = 1;
    endtask

    // Applies a phase at cycle 0 and runs a bounded number of cycles, logging
    // accepts, transfers and PhaseDone; reads return 'lat' cycles after accept.
    task automatic run_phase(input logic [1:0] code, input logic [31:0] base,
                             input int mode, input int lat, input int max_cyc);
        n_cmd = 0; done_cnt = 0; done_cyc = -1; last_xf_cyc = -1;
        unstable = 0; first_valid = -1; cyc = 0;
        for (int j = 0; j < 4; j++) xf_cnt[j] = 0;
        ret_q.delete();
        prev_stall = 0; prev_addr = 0; prev_cmd = 0;
        DRAMCommandReady  = 0;
        DRAMReadDataValid = 0;
        set_flags(code);
        PathAddress = base;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            cyc++;
            for (int j = 0; j < 4; j++) begin
                if (o_xf[j]) begin
                    xf_cnt[j]++;
                    last_xf_cyc = cyc;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall && (!o_valid || o_addr != prev_addr || o_cmd != prev_cmd)) unstable++;
            if (o_valid && first_valid < 0) first_valid = cyc;
            DRAMCommandReady  = (cyc >= 2) && (mode == 0 || (cyc % 2) == 1);
            DRAMReadDataValid = 0;
            if (ret_q.size() > 0 && ret_q[0] == cyc) begin
                void'(ret_q.pop_front());
                DRAMReadDataValid = 1;
            end
            if (o_valid && DRAMCommandReady) begin
                if (n_cmd < 16) begin
                    addr_log[n_cmd] = o_addr;
                    acc_cyc[n_cmd]  = cyc;
                end
                n_cmd++;
                if (!o_cmd) ret_q.push_back(cyc + lat);
            end
            prev_stall = o_valid && !DRAMCommandReady;
            prev_addr  = o_addr;
            prev_cmd   = o_cmd;
        end
        DRAMCommandReady  = 0;
        DRAMReadDataValid = 0;
    endtask

    initial begin
        int          acc;
        int          pulses;
        logic [31:0] exp_a;

        vecs[0] = '{2'b00, 32'h0000_1000, 0, 4};
        vecs[1] = '{2'b01, 32'h0000_2000, 1, 4};
        vecs[2] = '{2'b10, 32'hFFFF_FFC0, 0, 2};
        vecs[3] = '{2'b11, 32'h0000_3000, 0, 0};

        // Reset values
        dsel = 0;
        do_reset();
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_cmd",   {31'b0, o_cmd},   32'h0);
        chk("rst_addr",  o_addr,           32'h0);
        chk("rst_xf",    {28'b0, o_xf},    32'h0);
        chk("rst_done",  {31'b0, o_done},  32'h0);
        chk("rst_err",   {31'b0, o_err},   32'h0);

        // Table-driven phases on the default-parameter DUT
        for (int i = 0; i < 4; i++) begin
            do_reset();
            dsel = 0;
            run_phase(vecs[i].code, vecs[i].base, vecs[i].ready_mode, 3, 40);
            chk($sformatf("v%0d_ncmd", i), n_cmd, vecs[i].exp_n);
            for (int k = 0; k < vecs[i].exp_n; k++) begin
                exp_a = vecs[i].base + 32'(k * 64);
                chk($sformatf("v%0d_addr%0d", i, k), addr_log[k], exp_a);
            end
            for (int j = 0; j < 4; j++)
                chk($sformatf("v%0d_xf%0d", i, j), xf_cnt[j], (j == int'(vecs[i].code)) ? vecs[i].exp_n : 0);
            chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            if (vecs[i].exp_n == 0) begin
                chk($sformatf("v%0d_done_cyc", i), done_cyc, 2);
                chk($sformatf("v%0d_no_valid", i), first_valid, 32'hFFFF_FFFF);
            end else begin
                chk($sformatf("v%0d_done_after_xf", i), done_cyc, last_xf_cyc + 1);
                chk($sformatf("v%0d_first_valid", i), first_valid, 2);
            end
            chk($sformatf("v%0d_stable", i), unstable, 0);
            chk($sformatf("v%0d_err", i), {31'b0, o_err}, 32'h0);
        end

        // MaxOutstanding = 1: second read waits for the first return
        do_reset();
        dsel = 1;
        run_phase(2'b10, 32'h0000_4000, 0, 10, 40);
        chk("mo1_ncmd",   n_cmd,      2);
        chk("mo1_addr1",  addr_log[1], 32'h0000_4040);
        chk("mo1_acc0",   acc_cyc[0], 2);
        chk("mo1_acc1",   acc_cyc[1], 13);
        chk("mo1_xf_ror", xf_cnt[2],  2);
        chk("mo1_xf_rwr", xf_cnt[0],  0);
        chk("mo1_done",   done_cnt,   1);
        chk("mo1_err",    {31'b0, o_err}, 32'h0);
        dsel = 0;

        // Spurious return in IDLE, then a phase change mid-ISSUE
        do_reset();
        tick();
        DRAMReadDataValid = 1;
        tick();
        DRAMReadDataValid = 0;
        chk("spur_err", {31'b0, o_err}, 32'h1);
        chk("spur_xf",  {28'b0, o_xf},  32'h0);
        set_flags(2'b00);
        PathAddress = 32'h0000_1000;
        tick();
        tick();
        chk("ab_valid0", {31'b0, o_valid}, 32'h1);
        chk("ab_addr0",  o_addr, 32'h0000_1000);
        DRAMCommandReady = 1;
        tick();
        DRAMCommandReady = 0;
        chk("ab_addr1",  o_addr, 32'h0000_1040);
        run_phase(2'b10, 32'h0000_5000, 0, 3, 40);
        chk("ab_ncmd",   n_cmd, 2);
        chk("ab_new0",   addr_log[0], 32'h0000_5000);
        chk("ab_new1",   addr_log[1], 32'h0000_5040);
        chk("ab_xf_ror", xf_cnt[2], 2);
        chk("ab_xf_rwr", xf_cnt[0], 0);
        chk("ab_done",   done_cnt, 1);
        chk("ab_err",    {31'b0, o_err}, 32'h1);

        // Reset during DRAIN with two reads outstanding
        do_reset();
        set_flags(2'b00);
        PathAddress = 32'h0000_1000;
        DRAMCommandReady = 1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (o_valid) acc++;
            if (acc == 4) break;
        end
        tick();
        DRAMCommandReady = 0;
        chk("rd_accepts", acc, 4);
        DRAMReadDataValid = 1;
        tick();
        tick();
        DRAMReadDataValid = 0;
        Reset = 0;
        clear_flags();
        tick();
        chk("rd_rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rd_rst_cmd",   {31'b0, o_cmd},   32'h0);
        chk("rd_rst_addr",  o_addr,           32'h0);
        chk("rd_rst_xf",    {28'b0, o_xf},    32'h0);
        chk("rd_rst_done",  {31'b0, o_done},  32'h0);
        chk("rd_rst_err",   {31'b0, o_err},   32'h0);
        Reset = 1;
        DRAMReadDataValid = 1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 1) DRAMReadDataValid = 0;
            if (o_xf != 4'b0 || o_done) pulses++;
        end
        chk("late_pulses", pulses, 0);
        chk("late_err",    {31'b0, o_err}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
